// File: rtl/datapath_pkg.sv
// Shared scalar datapath types: FU count, FU index and the writeback request payload.
package datapath_pkg;

  localparam int NUM_FU_S = 4;
  localparam int REG_W_S  = 5;
  localparam int DATA_W_S = 32;
  localparam int FU_IDX_W = $clog2(NUM_FU_S);

  typedef logic [FU_IDX_W-1:0] fu_idx_t;

  typedef struct packed {
    logic [REG_W_S-1:0]  rd;
    logic [DATA_W_S-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/fust_s_wb_arb_rr_arbiter.sv
// Combinational rotating-priority arbiter: searches req starting at ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 enable,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      int                   cand;
      logic [$clog2(N)-1:0] ci;
      // Explicit subtract keeps the wrap correct when N is not a power of two.
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      ci = ($clog2(N))'(cand);
      if (enable && !valid && req[ci]) begin
        valid   = 1'b1;
        gnt[ci] = 1'b1;
        idx     = ci;
      end
    end
  end

endmodule

// File: rtl/fust_s_wb_arb.sv
// Scalar FU writeback scheduler: round-robin onto one regfile port through a one-entry
// output stage, reporting the FU row to clear in the status table on every retire.
module fust_s_wb_arb
  import datapath_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_S,
  parameter int REG_W  = REG_W_S,
  parameter int DATA_W = DATA_W_S,
  parameter int CNT_W  = 16
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NUM_FU-1:0]        fu_done,
  input  logic [NUM_FU*REG_W-1:0]  fu_rd,
  input  logic [NUM_FU*DATA_W-1:0] fu_data,
  output logic [NUM_FU-1:0]        fu_ack,
  output logic                     wb_valid,
  output logic                     wb_we,
  output logic [REG_W-1:0]         wb_rd,
  output logic [DATA_W-1:0]        wb_data,
  input  logic                     wb_ready,
  output logic                     fust_clr_en,
  output fu_idx_t                  fust_clr_fu,
  output logic [CNT_W-1:0]         stall_cnt
);

  fu_idx_t ptr;
  fu_idx_t gnt_idx;
  fu_idx_t clr_fu_q;
  logic    gnt_valid;
  logic    stage_free;
  wb_req_t sel_req;
  wb_req_t wb_q;

  assign stage_free = ~wb_valid | wb_ready;

  // Gating with nRST keeps fu_ack and the clear pulse quiet for the whole reset cycle.
  rr_arbiter #(.N(NUM_FU)) u_rr (
    .req    (fu_done),
    .ptr    (ptr),
    .enable (stage_free & nRST),
    .gnt    (fu_ack),
    .idx    (gnt_idx),
    .valid  (gnt_valid)
  );

  always_comb begin
    sel_req = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (fu_ack[i]) begin
        sel_req.rd   = fu_rd[i*REG_W +: REG_W];
        sel_req.data = fu_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ptr       <= '0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_q      <= '0;
      clr_fu_q  <= '0;
      stall_cnt <= '0;
    end else begin
      if (gnt_valid) begin
        wb_valid <= 1'b1;
        wb_q     <= sel_req;
        wb_we    <= (sel_req.rd != '0);
        clr_fu_q <= gnt_idx;
        ptr      <= (gnt_idx == fu_idx_t'(NUM_FU - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (wb_valid && wb_ready) begin
        wb_valid <= 1'b0;
      end
      if (wb_valid && !wb_ready && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  assign wb_rd       = wb_q.rd;
  assign wb_data     = wb_q.data;
  assign fust_clr_en = wb_valid & wb_ready & nRST;
  assign fust_clr_fu = clr_fu_q;

endmodule

// File: tb/tb_fust_s_wb_arb.sv
// Directed bench for fust_s_wb_arb with CNT_W=4 so stall counter saturation is reachable.
module tb_fust_s_wb_arb;
  import datapath_pkg::*;

  localparam int NF = 4;
  localparam int RW = 5;
  localparam int DW = 32;
  localparam int CW = 4;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [NF-1:0]    fu_done;
  logic [NF*RW-1:0] fu_rd;
  logic [NF*DW-1:0] fu_data;
  logic [NF-1:0]    fu_ack;
  logic             wb_valid, wb_we, wb_ready, fust_clr_en;
  logic [RW-1:0]    wb_rd;
  logic [DW-1:0]    wb_data;
  fu_idx_t          fust_clr_fu;
  logic [CW-1:0]    stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  fust_s_wb_arb #(.NUM_FU(NF), .REG_W(RW), .DATA_W(DW), .CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .fu_done(fu_done), .fu_rd(fu_rd), .fu_data(fu_data),
    .fu_ack(fu_ack), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_ready(wb_ready), .fust_clr_en(fust_clr_en),
    .fust_clr_fu(fust_clr_fu), .stall_cnt(stall_cnt)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; wb_ready = 1'b1; fu_done = 4'b1111; fu_rd = '0; fu_data = '0;
    #2;
    n_tests++; if (fu_ack !== 4'b0000) begin n_fail++; $display("FAIL rst_ack got=%b exp=0000", fu_ack); end
    n_tests++; if (fust_clr_en !== 1'b0) begin n_fail++; $display("FAIL rst_clr got=%b exp=0", fust_clr_en); end
    tick(); tick();
    nRST = 1'b1; fu_done = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_tests++;
      if (wb_valid !== 1'b0 || fu_ack !== 4'b0000 || stall_cnt !== 4'd0) begin
        n_fail++; $display("FAIL idle c=%0d valid=%b ack=%b stall=%0d exp 0/0000/0", c, wb_valid, fu_ack, stall_cnt);
      end
    end
  endtask

  task automatic test_single();
    fu_done = 4'b0100; fu_rd[2*RW +: RW] = 5'd7; fu_data[2*DW +: DW] = 32'hDEADBEEF; wb_ready = 1'b1;
    #1;
    n_tests++; if (fu_ack !== 4'b0100) begin n_fail++; $display("FAIL single_ack got=%b exp=0100", fu_ack); end
    tick();
    fu_done = '0;
    #1;
    n_tests++; if (wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'hDEADBEEF || wb_we !== 1'b1) begin
      n_fail++; $display("FAIL single_wb valid=%b rd=%0d data=%h we=%b exp 1/7/deadbeef/1", wb_valid, wb_rd, wb_data, wb_we);
    end
    n_tests++; if (fust_clr_en !== 1'b1 || fust_clr_fu !== 2'd2) begin
      n_fail++; $display("FAIL single_clr en=%b fu=%0d exp 1/2", fust_clr_en, fust_clr_fu);
    end
    tick();
    n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got=%b exp=0", wb_valid); end
  endtask

  task automatic test_all_four();
    nRST = 1'b0; tick(); nRST = 1'b1;
    for (int i = 0; i < NF; i++) begin
      fu_rd[i*RW +: RW] = RW'(10 + i);
      fu_data[i*DW +: DW] = 32'hA0 + 32'(i);
    end
    fu_done = 4'b1111;
    for (int k = 0; k < NF; k++) begin
      #1;
      n_tests++; if (fu_ack !== 4'(1 << k)) begin n_fail++; $display("FAIL all4_ack k=%0d got=%b exp=%b", k, fu_ack, 4'(1 << k)); end
      tick();
      fu_done[k] = 1'b0;
      n_tests++;
      if (wb_valid !== 1'b1 || wb_rd !== RW'(10 + k) || wb_data !== 32'hA0 + 32'(k) || fust_clr_fu !== 2'(k)) begin
        n_fail++; $display("FAIL all4_wb k=%0d valid=%b rd=%0d data=%h fu=%0d", k, wb_valid, wb_rd, wb_data, fust_clr_fu);
      end
    end
    // FU0 winning over FU3 shows the pointer wrapped back to 0.
    fu_done = 4'b1001;
    #1;
    n_tests++; if (fu_ack !== 4'b0001) begin n_fail++; $display("FAIL ptr_wrap got=%b exp=0001", fu_ack); end
    tick();
    fu_done = '0;
    n_tests++; if (wb_rd !== 5'd10 || fust_clr_fu !== 2'd0) begin
      n_fail++; $display("FAIL ptr_wrap_wb rd=%0d fu=%0d exp 10/0", wb_rd, fust_clr_fu);
    end
    tick();
  endtask

  task automatic test_backpressure();
    fu_rd[1*RW +: RW] = 5'd21; fu_data[1*DW +: DW] = 32'h1111_0001;
    fu_rd[3*RW +: RW] = 5'd23; fu_data[3*DW +: DW] = 32'h3333_0003;
    fu_done = 4'b1010; wb_ready = 1'b0;
    #1;
    n_tests++; if (fu_ack !== 4'b0010) begin n_fail++; $display("FAIL bp_first got=%b exp=0010", fu_ack); end
    tick();
    fu_done = 4'b1000;
    for (int j = 0; j < 3; j++) begin
      #1;
      n_tests++;
      if (fu_ack !== 4'b0000 || wb_rd !== 5'd21 || wb_data !== 32'h1111_0001 || wb_valid !== 1'b1 || fust_clr_en !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold j=%0d ack=%b rd=%0d data=%h valid=%b clr=%b", j, fu_ack, wb_rd, wb_data, wb_valid, fust_clr_en);
      end
      tick();
    end
    n_tests++; if (stall_cnt !== 4'd3) begin n_fail++; $display("FAIL bp_stall got=%0d exp=3", stall_cnt); end
    wb_ready = 1'b1;
    #1;
    n_tests++; if (fust_clr_en !== 1'b1 || fust_clr_fu !== 2'd1 || fu_ack !== 4'b1000) begin
      n_fail++; $display("FAIL bp_release clr=%b fu=%0d ack=%b exp 1/1/1000", fust_clr_en, fust_clr_fu, fu_ack);
    end
    tick();
    fu_done = '0;
    #1;
    n_tests++; if (wb_valid !== 1'b1 || wb_rd !== 5'd23 || fust_clr_fu !== 2'd3 || stall_cnt !== 4'd3 || fu_ack !== 4'b0000) begin
      n_fail++; $display("FAIL bp_reload valid=%b rd=%0d fu=%0d stall=%0d ack=%b", wb_valid, wb_rd, fust_clr_fu, stall_cnt, fu_ack);
    end
    tick();
    n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b exp=0", wb_valid); end
  endtask

  task automatic test_rd_zero();
    fu_rd[0 +: RW] = 5'd0; fu_data[0 +: DW] = 32'h0000_1234;
    fu_done = 4'b0001;
    #1;
    n_tests++; if (fu_ack !== 4'b0001) begin n_fail++; $display("FAIL rd0_ack got=%b exp=0001", fu_ack); end
    tick();
    fu_done = '0;
    #1;
    n_tests++; if (wb_valid !== 1'b1 || wb_we !== 1'b0 || wb_rd !== 5'd0 || fust_clr_en !== 1'b1 || fust_clr_fu !== 2'd0) begin
      n_fail++; $display("FAIL rd0_wb valid=%b we=%b rd=%0d clr=%b fu=%0d exp 1/0/0/1/0", wb_valid, wb_we, wb_rd, fust_clr_en, fust_clr_fu);
    end
    tick();
  endtask

  task automatic test_reset_stall_sat();
    fu_rd[2*RW +: RW] = 5'd9; fu_data[2*DW +: DW] = 32'h9999_9999;
    fu_done = 4'b0100; wb_ready = 1'b0;
    #1;
    n_tests++; if (fu_ack !== 4'b0100) begin n_fail++; $display("FAIL rs_ack got=%b exp=0100", fu_ack); end
    tick();
    fu_done = '0;
    tick();
    nRST = 1'b0; wb_ready = 1'b1; fu_done = 4'b0001;
    #1;
    n_tests++; if (fust_clr_en !== 1'b0 || fu_ack !== 4'b0000) begin
      n_fail++; $display("FAIL rs_gate clr=%b ack=%b exp 0/0000", fust_clr_en, fu_ack);
    end
    tick();
    n_tests++;
    if (wb_valid !== 1'b0 || wb_we !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0 || stall_cnt !== 4'd0 || fust_clr_fu !== 2'd0) begin
      n_fail++; $display("FAIL rs_state valid=%b we=%b rd=%0d data=%h stall=%0d fu=%0d", wb_valid, wb_we, wb_rd, wb_data, stall_cnt, fust_clr_fu);
    end
    nRST = 1'b1; fu_done = 4'b0010; wb_ready = 1'b0;
    fu_rd[1*RW +: RW] = 5'd3;
    #1;
    n_tests++; if (fu_ack !== 4'b0010) begin n_fail++; $display("FAIL sat_ack got=%b exp=0010", fu_ack); end
    tick();
    fu_done = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 15) begin
        n_tests++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_15 got=%0d exp=15", stall_cnt); end
      end
    end
    n_tests++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_20 got=%0d exp=15", stall_cnt); end
    wb_ready = 1'b1;
    #1;
    n_tests++; if (fust_clr_en !== 1'b1 || fust_clr_fu !== 2'd1) begin
      n_fail++; $display("FAIL sat_retire clr=%b fu=%0d exp 1/1", fust_clr_en, fust_clr_fu);
    end
    tick();
    n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL sat_drain got=%b exp=0", wb_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_rd_zero();
    test_reset_stall_sat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fust_s_wb_arb.md
Name: fust_s_wb_arb

Overview:
- Writeback scheduler for the scalar functional units tracked by the scalar FU status table.
- Arbitrates NUM_FU completing units onto the single scalar register-file write port, using round-robin with a one-entry registered output stage.
- On each retired writeback, emits the FU index whose status row must be cleared.
- Sits between the scalar FU outputs and the regfile/status-table update logic.

Parameters:
NUM_FU, 4, number of scalar functional units (requesters)
REG_W, 5, destination register index width
DATA_W, 32, writeback data width
CNT_W, 16, width of the saturating stall counter

Ports:
CLK  in  1  clock; all state updates on rising edge
nRST  in  1  reset, synchronous, active-low
fu_done  in  NUM_FU  per-FU result valid; held high until that FU's fu_ack
fu_rd  in  NUM_FU*REG_W  per-FU destination register
fu_data  in  NUM_FU*DATA_W  per-FU result data
fu_ack  out  NUM_FU  one-hot grant; combinational; at most one bit high
wb_valid  out  1  output stage holds a writeback
wb_we  out  1  regfile write enable qualifier (0 when rd==0)
wb_rd  out  REG_W  writeback destination
wb_data  out  DATA_W  writeback data
wb_ready  in  1  regfile port accepts this cycle
fust_clr_en  out  1  pulse: clear busy of row fust_clr_fu
fust_clr_fu  out  $clog2(NUM_FU)  FU index to clear
stall_cnt  out  CNT_W  saturating count of cycles with wb_valid & ~wb_ready

Behaviour:
- Reset (nRST==0 at rising edge): ptr=0, wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, stall_cnt=0, stored FU index=0. fu_ack=0 and fust_clr_en=0 while in reset.
- Output stage "free" = ~wb_valid | wb_ready.
- Grant: when free and |fu_done, pick the first i in the order ptr, ptr+1, ..., wrapping modulo NUM_FU, with fu_done[i]=1. fu_ack[i]=1 in that same cycle.
- When not free: fu_ack=0 and ptr holds.
- On grant edge:
  - wb_valid<=1, wb_rd<=fu_rd[i], wb_data<=fu_data[i], wb_we<=(fu_rd[i]!=0), stored FU index<=i.
  - ptr<=(i+1) mod NUM_FU; the wrap must be correct for non-power-of-2 NUM_FU.
- Latency: fu_done rising at cycle t with the stage free gives fu_ack at t and wb_valid at t+1. Sustained throughput is 1 writeback per cycle while wb_ready=1.
- Retire: cycle with wb_valid & wb_ready.
  - fust_clr_en=1 (combinational), fust_clr_fu=stored index.
  - If no new grant in that cycle, wb_valid<=0 next edge.
  - Retire and a new grant in the same cycle is legal: the stage is reloaded and wb_valid stays 1.
- rd==0 results are still granted and retired, with wb_we=0. This is required so the status row is cleared.
- Stall: while wb_valid & ~wb_ready, outputs hold stable, stall_cnt increments, and it saturates at 2^CNT_W-1 with no wrap.
- Fairness: any FU holding fu_done is acked within NUM_FU grant opportunities.
- A grant to FU i does not require fu_done[i] to drop in the next cycle. The FU deasserts on its own after the ack, and the block must not double-grant: it sees fu_ack as the consume event.
- Reset asserted mid-stall: the pending writeback is discarded, with no fust_clr_en.

Decomposition:
- datapath_pkg: NUM_FU_S constant, fu_idx_t typedef, and wb_req_t struct {rd, data}. The fust_s_wb_arb ports use these types.
- Sub-module rr_arbiter (parameter N): inputs req[N], ptr, enable; outputs one-hot gnt and an encoded index. Purely combinational; it is reused for issue-side arbitration later.

Test Plan:
- Reset then idle: fu_done=0 for 5 cycles -> wb_valid=0, fu_ack=0, stall_cnt=0.
- Single request: fu_done=4'b0100, rd=7, data=0xDEADBEEF, wb_ready=1 -> fu_ack=0100 at t; at t+1 wb_valid=1, wb_rd=7, wb_data=0xDEADBEEF, fust_clr_en=1, fust_clr_fu=2.
- All four request simultaneously, each holding until acked, wb_ready=1 -> acks in order FU0, FU1, FU2, FU3 on consecutive cycles, and ptr returns to 0.
- Backpressure: FU1 and FU3 request, wb_ready=0 for 3 cycles -> FU1 granted, outputs frozen, stall_cnt=3, FU3 not acked. When wb_ready=1, FU1 retires and FU3 is acked in the same cycle.
- rd=0: FU0 completes with rd=0 -> wb_valid=1, wb_we=0, fust_clr_en=1 with fust_clr_fu=0.
- Reset during stall, then the stall_cnt saturation case (CNT_W=4, 20 stall cycles -> 15).
